// File: rtl/sad_search_ctrl_if.sv
// Handshake bundle between the SAD array, the search
// controller and the motion-vector writeback stage.
interface sad_search_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             start;
  logic [69:0]      sad_vec;
  logic             sad_valid;
  logic             sad_ready;
  logic             busy;
  logic [13:0]      best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start, sad_vec, sad_valid, done_ready,
    input  sad_ready, busy, best_sad, best_idx,
    input  done_valid
  );

  modport slave (
    input  start, sad_vec, sad_valid, done_ready,
    output sad_ready, busy, best_sad, best_idx,
    output done_valid
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// Block-matching search sequencer: per-group 5-way SAD
// minimum, running best across groups, valid/ready result.
module sad_search_ctrl #(
  parameter int NUM_GROUPS = 9,
  parameter int IDX_W      = $clog2(NUM_GROUPS*5)
) (
  input logic          clk,
  input logic          rst_n,
  sad_search_ctrl_if.slave bus
);
  localparam int CNT_W =
    (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE, SEARCH, DRAIN, DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic             r_s1_valid;
  logic [13:0]      r_s1_sad;
  logic [2:0]       r_s1_k;
  logic [CNT_W-1:0] r_s1_grp;
  logic [13:0]      r_best_sad;
  logic [IDX_W-1:0] r_best_idx;

  logic             w_sad_ready;
  logic             w_busy;
  logic             w_done_valid;
  logic             w_accept;
  logic             w_load;
  logic [13:0]      w_min_sad;
  logic [2:0]       w_min_k;
  logic [IDX_W-1:0] w_s1_idx;

  assign w_accept = bus.sad_valid & w_sad_ready;

  // Ascending scan with strict compare keeps lowest k on ties.
  always_comb begin
    w_min_sad = bus.sad_vec[13:0];
    w_min_k   = 3'd0;
    for (int k = 1; k < 5; k++) begin
      if (bus.sad_vec[14*k +: 14] < w_min_sad) begin
        w_min_sad = bus.sad_vec[14*k +: 14];
        w_min_k   = 3'(k);
      end
    end
  end

  assign w_s1_idx = IDX_W'(r_s1_grp) * IDX_W'(3'd5)
                  + IDX_W'(r_s1_k);

  // First group loads outright; later ones need strictly less.
  assign w_load = r_s1_valid &
                  (r_first | (r_s1_sad < r_best_sad));

  // Next state and handshake outputs.
  always_comb begin
    w_next       = r_state;
    w_sad_ready  = 1'b0;
    w_busy       = 1'b1;
    w_done_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = SEARCH;
      end
      SEARCH: begin
        w_sad_ready = 1'b1;
        if (bus.sad_valid && r_cnt == LAST)
          w_next = DRAIN;
      end
      DRAIN: begin
        if (!r_s1_valid) w_next = DONE;
      end
      DONE: begin
        w_done_valid = 1'b1;
        if (bus.done_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Group counter and first-group flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else begin
      if (w_accept)   r_cnt   <= r_cnt + 1'b1;
      if (r_s1_valid) r_first <= 1'b0;
    end
  end

  // Stage 1: group minimum captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sad   <= '0;
      r_s1_k     <= '0;
      r_s1_grp   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sad <= w_min_sad;
        r_s1_k   <= w_min_k;
        r_s1_grp <= r_cnt;
      end
    end
  end

  // Stage 2: fold group minimum into running best.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_sad <= '0;
      r_best_idx <= '0;
    end else if (w_load) begin
      r_best_sad <= r_s1_sad;
      r_best_idx <= w_s1_idx;
    end
  end

  assign bus.sad_ready  = w_sad_ready;
  assign bus.busy       = w_busy;
  assign bus.done_valid = w_done_valid;
  assign bus.best_sad   = r_best_sad;
  assign bus.best_idx   = r_best_idx;
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: vector table, corner
// sequences and randomized searches vs a reference model.
module tb_sad_search_ctrl;
  localparam int NG = 9;
  localparam int NC = NG * 5;

  typedef logic [13:0] sads_t [NC];

  typedef struct {
    logic [13:0] base;
    int          ia;
    logic [13:0] va;
    int          ib;
    logic [13:0] vb;
    int          bub;
    int          hold;
    logic [13:0] xs;
    int          xi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  sad_search_ctrl_if #(.IDX_W(6)) bus ();

  sad_search_ctrl #(.NUM_GROUPS(NG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic [69:0] pack(input sads_t s,
                                        input int g);
    logic [69:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[14*k +: 14] = s[g*5+k];
    return v;
  endfunction

  // Whole-search argmin; first index wins on ties.
  function automatic void ref_best(input sads_t s,
                                   output logic [13:0] bs,
                                   output int bi);
    bs = s[0];
    bi = 0;
    for (int i = 1; i < NC; i++)
      if (s[i] < bs) begin
        bs = s[i];
        bi = i;
      end
  endfunction

  task automatic run_search(input sads_t s,
                            input int bub,
                            input int hold,
                            input logic [13:0] xs,
                            input int xi,
                            input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if ($urandom_range(0, 99) < bub) begin
        int nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          bus.sad_valid = 1'b0;
          bus.sad_vec = '0;
          @(negedge clk);
          chk({tag, " bubble_ready"}, 32'(bus.sad_ready), 1);
          tick();
        end
      end
      bus.sad_vec   = pack(s, g);
      bus.sad_valid = 1'b1;
      @(negedge clk);
      chk({tag, " beat_ready"}, 32'(bus.sad_ready), 1);
      tick();
    end
    // Zero SADs offered after the last beat must not be taken.
    bus.sad_vec   = '0;
    bus.sad_valid = 1'b1;
    @(negedge clk);
    chk({tag, " drain_ready"}, 32'(bus.sad_ready), 0);
    chk({tag, " lat_n0"}, 32'(bus.done_valid), 0);
    tick();
    @(negedge clk);
    chk({tag, " lat_n1"}, 32'(bus.done_valid), 0);
    chk({tag, " busy_n1"}, 32'(bus.busy), 1);
    tick();
    @(negedge clk);
    chk({tag, " lat_n2"}, 32'(bus.done_valid), 1);
    chk({tag, " best_sad"}, 32'(bus.best_sad), 32'(xs));
    chk({tag, " best_idx"}, 32'(bus.best_idx), 32'(xi));
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      tick();
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(bus.done_valid), 1);
      chk({tag, " hold_ready"}, 32'(bus.sad_ready), 0);
      chk({tag, " hold_sad"}, 32'(bus.best_sad), 32'(xs));
      chk({tag, " hold_idx"}, 32'(bus.best_idx), 32'(xi));
    end
    // start during the handshake cycle must be dropped.
    bus.done_ready = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    bus.start      = 1'b0;
    bus.sad_valid  = 1'b0;
    @(negedge clk);
    chk({tag, " post_valid"}, 32'(bus.done_valid), 0);
    chk({tag, " post_busy"}, 32'(bus.busy), 0);
    chk({tag, " keep_idx"}, 32'(bus.best_idx), 32'(xi));
  endtask

  vec_t  tbl[9];
  sads_t s;

  initial begin
    tbl[0] = '{100, 33, 7, -1, 0, 0, 0, 7, 33};
    tbl[1] = '{50, -1, 0, -1, 0, 0, 0, 50, 0};
    tbl[2] = '{60, 22, 20, 24, 20, 0, 0, 20, 22};
    tbl[3] = '{14'h3FFF, -1, 0, -1, 0, 0, 0, 14'h3FFF, 0};
    tbl[4] = '{14'h3FFF, -1, 0, -1, 0, 60, 0, 14'h3FFF, 0};
    tbl[5] = '{100, 33, 7, -1, 0, 0, 10, 7, 33};
    tbl[6] = '{1, 44, 0, -1, 0, 0, 0, 0, 44};
    tbl[7] = '{9, 0, 2, 44, 2, 30, 2, 2, 0};
    tbl[8] = '{200, 5, 199, 4, 199, 0, 0, 199, 4};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.sad_vec    = '0;
    bus.sad_valid  = 1'b0;
    bus.done_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    bus.sad_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      chk("idle_ready", 32'(bus.sad_ready), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_done", 32'(bus.done_valid), 0);
    end
    chk("rst_sad", 32'(bus.best_sad), 0);
    chk("rst_idx", 32'(bus.best_idx), 0);
    bus.sad_valid = 1'b0;

    foreach (tbl[r]) begin
      for (int i = 0; i < NC; i++) s[i] = tbl[r].base;
      if (tbl[r].ia >= 0) s[tbl[r].ia] = tbl[r].va;
      if (tbl[r].ib >= 0) s[tbl[r].ib] = tbl[r].vb;
      run_search(s, tbl[r].bub, tbl[r].hold,
                 tbl[r].xs, tbl[r].xi,
                 $sformatf("tbl%0d", r));
    end

    // Reset after four beats of very small SADs.
    for (int i = 0; i < NC; i++) s[i] = 14'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      bus.sad_vec   = pack(s, g);
      bus.sad_valid = 1'b1;
      tick();
    end
    bus.sad_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ready", 32'(bus.sad_ready), 0);
    chk("mid_rst_done", 32'(bus.done_valid), 0);
    chk("mid_rst_sad", 32'(bus.best_sad), 0);
    chk("mid_rst_idx", 32'(bus.best_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NC; i++) s[i] = 14'd500;
    s[7] = 14'd300;
    run_search(s, 0, 0, 14'd300, 7, "after_rst");

    for (int t = 0; t < 12; t++) begin
      logic [13:0] xs;
      int          xi;
      for (int i = 0; i < NC; i++)
        s[i] = (t % 3 == 0) ? 14'($urandom())
                            : 14'($urandom_range(3, 20));
      ref_best(s, xs, xi);
      run_search(s, $urandom_range(0, 50),
                 $urandom_range(0, 3), xs, xi,
                 $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
